regfile_mp_scoreboard: RTL and testbench

//  Parametrised multi-port integer register file with a per-register busy scoreboard.
//  - Provides NRD combinational read ports and NWR synchronous write ports.
//  - Register 0 is hardwired to zero.
//  - Tracks pending writebacks so issue logic can stall on RAW hazards.
//  - Sits between decode/issue (reads, issue marks) and writeback (writes, busy clears).

---
 rtl/regfile_mp_scoreboard_if.sv | 31 +++
 rtl/regfile_mp_scoreboard.sv | 87 ++++++++
 tb/tb_regfile_mp_scoreboard.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_scoreboard_if.sv
// Bundle of register-file read, write, issue and scoreboard signals.
// The master side is the issue/writeback pipeline; the slave side is the register file.
interface regfile_mp_scoreboard_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                flush;
  logic [NREGS-1:0]    busy_vec;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_valid, iss_rd, flush,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_valid, iss_rd, flush,
    output rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port register file (r0 hardwired to zero) with a per-register busy scoreboard.
// Optional macro REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding.
module regfile_mp_scoreboard #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_mp_scoreboard_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  regs   [NREGS];
  logic [XLEN-1:0]  wr_val [NREGS];
  logic [NREGS-1:0] wr_hit;
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;

  // Ports are scanned in ascending order so the highest-index writer wins.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      wr_hit[r] = 1'b0;
      wr_val[r] = '0;
    end
    for (int j = 0; j < NWR; j++) begin
      if (bus.wr_en[j] && (bus.wr_addr[j*AW +: AW] != '0)) begin
        wr_hit[bus.wr_addr[j*AW +: AW]] = 1'b1;
        wr_val[bus.wr_addr[j*AW +: AW]] = bus.wr_data[j*XLEN +: XLEN];
      end
    end
  end

  // Set beats clear: a newly issued producer is still outstanding.
  always_comb begin
    busy_nxt = '0;
    for (int r = 1; r < NREGS; r++) begin
      if (bus.flush)
        busy_nxt[r] = 1'b0;
      else if (bus.iss_valid && (bus.iss_rd == AW'(r)))
        busy_nxt[r] = 1'b1;
      else if (wr_hit[r])
        busy_nxt[r] = 1'b0;
      else
        busy_nxt[r] = busy[r];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      busy <= '0;
    end else begin
      busy <= busy_nxt;
      for (int r = 1; r < NREGS; r++) begin
        if (wr_hit[r]) regs[r] <= wr_val[r];
      end
    end
  end

  always_comb begin
    logic [AW-1:0] a;
    bus.rd_data = '0;
    bus.rd_busy = '0;
    a           = '0;
    for (int k = 0; k < NRD; k++) begin
      a = bus.rd_addr[k*AW +: AW];
      if (a != '0) begin
        bus.rd_data[k*XLEN +: XLEN] = regs[a];
        bus.rd_busy[k]              = busy[a];
`ifdef REGFILE_BYPASS_EN
        // Forwarding is suppressed while reset is asserted so reads stay zero.
        for (int j = 0; j < NWR; j++) begin
          if (rst_n && bus.wr_en[j] && (bus.wr_addr[j*AW +: AW] == a)) begin
            bus.rd_data[k*XLEN +: XLEN] = bus.wr_data[j*XLEN +: XLEN];
            bus.rd_busy[k]              = busy[a] && bus.iss_valid && (bus.iss_rd == a);
          end
        end
`endif
      end
    end
  end

  assign bus.busy_vec = busy;

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Scoreboard bench: stimulus pushes expected read/scoreboard values from an array model;
// a monitor pops and compares on every falling edge.
module tb_regfile_mp_scoreboard;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = $clog2(NREGS);

  typedef struct {
    string               name;
    logic [NRD*XLEN-1:0] data;
    logic [NRD-1:0]      rbusy;
    logic [NREGS-1:0]    bvec;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t q[$];

  logic [XLEN-1:0]  mem [NREGS];
  logic [NREGS-1:0] mbusy;

  regfile_mp_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();

  regfile_mp_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < NREGS; r++) mem[r] = '0;
    mbusy = '0;
  endtask

  // Expected outputs come from the model state before this cycle's edge.
  task automatic expect_now(input string nm);
    exp_t e;
    logic [AW-1:0] a;
    e.name = nm;
    for (int k = 0; k < NRD; k++) begin
      a = bus.rd_addr[k*AW +: AW];
      e.data[k*XLEN +: XLEN] = (a == 0) ? '0 : mem[a];
      e.rbusy[k]             = (a == 0) ? 1'b0 : mbusy[a];
`ifdef REGFILE_BYPASS_EN
      if (rst_n && a != 0) begin
        for (int j = 0; j < NWR; j++) begin
          if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] == a) begin
            e.data[k*XLEN +: XLEN] = bus.wr_data[j*XLEN +: XLEN];
            e.rbusy[k] = mbusy[a] && bus.iss_valid && (bus.iss_rd == a);
          end
        end
      end
`endif
    end
    e.bvec = mbusy;
    q.push_back(e);
  endtask

  task automatic cycle(input string nm, input logic [NWR-1:0] we, input logic [NWR*AW-1:0] wa,
                       input logic [NWR*XLEN-1:0] wd, input logic iv, input logic [AW-1:0] ir,
                       input logic fl, input logic [NRD*AW-1:0] ra);
    logic [AW-1:0] a;
    @(posedge clk); #1;
    bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd;
    bus.iss_valid = iv; bus.iss_rd = ir; bus.flush = fl; bus.rd_addr = ra;
    expect_now(nm);
    // Apply this cycle's effects: data writes in port order, clears, then set, then flush.
    for (int j = 0; j < NWR; j++) begin
      a = wa[j*AW +: AW];
      if (we[j] && a != 0) begin
        mem[a] = wd[j*XLEN +: XLEN];
        mbusy[a] = 1'b0;
      end
    end
    if (iv && ir != 0) mbusy[ir] = 1'b1;
    if (fl) mbusy = '0;
  endtask

  task automatic reset_pulse(input string nm, input logic [NRD*AW-1:0] ra);
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.wr_en = '0; bus.iss_valid = 1'b0; bus.flush = 1'b0; bus.rd_addr = ra;
    model_clear();
    expect_now(nm);
    @(negedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int k = 0; k < NRD; k++)
          check($sformatf("%s rd_data[%0d]", e.name, k),
                64'(bus.rd_data[k*XLEN +: XLEN]), 64'(e.data[k*XLEN +: XLEN]));
        check($sformatf("%s rd_busy", e.name), 64'(bus.rd_busy), 64'(e.rbusy));
        check($sformatf("%s busy_vec", e.name), 64'(bus.busy_vec), 64'(e.bvec));
      end
    end
  end

  initial begin
    logic [NRD*AW-1:0] ra;
    logic [NWR*AW-1:0] wa;
    logic [NWR*XLEN-1:0] wd;
    bus.rd_addr = '0; bus.wr_en = '0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.iss_valid = 1'b0; bus.iss_rd = '0; bus.flush = 1'b0;
    model_clear();

    reset_pulse("in_reset", {5'd1, 5'd0});
    for (int i = 0; i < NREGS / 2; i++) begin
      ra = {AW'(2*i+1), AW'(2*i)};
      cycle("reset_read", 2'b00, '0, '0, 1'b0, '0, 1'b0, ra);
    end

    cycle("wr5",      2'b01, {5'd0, 5'd5}, {32'd0, 32'hDEADBEEF}, 1'b0, '0, 1'b0, {5'd0, 5'd5});
    cycle("rd5",      2'b00, '0, '0, 1'b0, '0, 1'b0, {5'd0, 5'd5});
    cycle("wr0",      2'b01, {5'd0, 5'd0}, {32'd0, 32'h1234}, 1'b0, '0, 1'b0, {5'd5, 5'd0});
    cycle("rd0",      2'b00, '0, '0, 1'b0, '0, 1'b0, {5'd0, 5'd0});

    cycle("wr7_both", 2'b11, {5'd7, 5'd7}, {32'h5555, 32'hAAAA}, 1'b0, '0, 1'b0, {5'd7, 5'd5});
    cycle("rd7",      2'b00, '0, '0, 1'b0, '0, 1'b0, {5'd5, 5'd7});

    cycle("iss9",     2'b00, '0, '0, 1'b1, 5'd9, 1'b0, {5'd0, 5'd9});
    cycle("busy9",    2'b00, '0, '0, 1'b0, '0, 1'b0, {5'd9, 5'd0});
    cycle("wb9",      2'b10, {5'd9, 5'd0}, {32'h99, 32'd0}, 1'b0, '0, 1'b0, {5'd0, 5'd9});
    cycle("clr9",     2'b00, '0, '0, 1'b0, '0, 1'b0, {5'd0, 5'd9});
    cycle("iss_wb9",  2'b01, {5'd0, 5'd9}, {32'd0, 32'h999}, 1'b1, 5'd9, 1'b0, {5'd9, 5'd0});
    cycle("still9",   2'b00, '0, '0, 1'b0, '0, 1'b0, {5'd0, 5'd9});

    cycle("iss3",     2'b00, '0, '0, 1'b1, 5'd3, 1'b0, {5'd0, 5'd3});
    cycle("iss4",     2'b00, '0, '0, 1'b1, 5'd4, 1'b0, {5'd0, 5'd4});
    cycle("iss5",     2'b00, '0, '0, 1'b1, 5'd5, 1'b0, {5'd5, 5'd3});
    cycle("flush6",   2'b00, '0, '0, 1'b1, 5'd6, 1'b1, {5'd6, 5'd4});
    cycle("flushed",  2'b00, '0, '0, 1'b0, '0, 1'b0, {5'd6, 5'd5});
    cycle("iss0",     2'b00, '0, '0, 1'b1, 5'd0, 1'b0, {5'd0, 5'd0});
    cycle("no_busy0", 2'b00, '0, '0, 1'b0, '0, 1'b0, {5'd0, 5'd0});

    cycle("pre12",    2'b01, {5'd0, 5'd12}, {32'd0, 32'h1111}, 1'b0, '0, 1'b0, {5'd0, 5'd0});
    cycle("iss12",    2'b00, '0, '0, 1'b1, 5'd12, 1'b0, {5'd0, 5'd12});
    cycle("byp12",    2'b01, {5'd0, 5'd12}, {32'd0, 32'hCAFE}, 1'b0, '0, 1'b0, {5'd12, 5'd12});
    cycle("after12",  2'b00, '0, '0, 1'b0, '0, 1'b0, {5'd0, 5'd12});

    for (int i = 0; i < 400; i++) begin
      wa = {AW'($urandom_range(0, NREGS-1)), AW'($urandom_range(0, NREGS-1))};
      wd = {32'($urandom), 32'($urandom)};
      ra = {AW'($urandom_range(0, NREGS-1)), AW'($urandom_range(0, NREGS-1))};
      if (i == 200)
        reset_pulse("mid_reset", ra);
      else
        cycle("rand", NWR'($urandom_range(0, 3)), wa, wd, 1'($urandom_range(0, 1)),
              AW'($urandom_range(0, NREGS-1)), ($urandom_range(0, 15) == 0), ra);
    end
    cycle("tail", 2'b00, '0, '0, 1'b0, '0, 1'b0, {5'd2, 5'd1});

    repeat (3) @(posedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
